// File: rtl/gate_selftest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gate_selftest_ctrl
//  Description : Self-test sequencer for the two-input AND/OR/XOR gate
//                datapath. Walks a/b through 00,01,10,11, holds each for
//                HOLD_CYCLES cycles, samples the gate outputs for one cycle
//                and accumulates a per-combination error map and count.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_selftest_ctrl #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_and,
    input  logic       y_or,
    input  logic       y_xor,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_vec,
    output logic [2:0] err_count
);

    localparam int                    c_HCNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_HCNT_W-1:0]   c_HCNT_LAST = c_HCNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [1:0]            r_idx,       w_idx_nxt;
    logic [c_HCNT_W-1:0]   r_hcnt,      w_hcnt_nxt;
    logic                  r_a,         w_a_nxt;
    logic                  r_b,         w_b_nxt;
    logic [3:0]            r_err_vec,   w_err_vec_nxt;
    logic [2:0]            r_err_count, w_err_count_nxt;

    logic [2:0]            w_expected;
    logic [2:0]            w_observed;
    logic                  w_mismatch;

    // Reference truth taken from the registered stimulus actually on the pins
    assign w_expected = {r_a & r_b, r_a | r_b, r_a ^ r_b};
    assign w_observed = {y_and, y_or, y_xor};
    assign w_mismatch = (w_expected != w_observed);

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_hcnt      <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_err_vec   <= 4'd0;
            r_err_count <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_err_vec   <= w_err_vec_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    // Next-state logic: sequencing, stimulus update and error accumulation
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_hcnt_nxt      = r_hcnt;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_err_vec_nxt   = r_err_vec;
        w_err_count_nxt = r_err_count;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // start is only honoured here; a held start restarts from DONE
                if (start) begin
                    w_state_nxt     = ST_DRIVE;
                    w_idx_nxt       = 2'd0;
                    w_hcnt_nxt      = '0;
                    w_a_nxt         = 1'b0;
                    w_b_nxt         = 1'b0;
                    w_err_vec_nxt   = 4'd0;
                    w_err_count_nxt = 3'd0;
                end
            end
            ST_DRIVE: begin
                w_hcnt_nxt = r_hcnt + 1'b1;
                if (r_hcnt == c_HCNT_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // Any wrong output bit flags the combination once
                if (w_mismatch) begin
                    w_err_vec_nxt[r_idx] = 1'b1;
                    w_err_count_nxt      = r_err_count + 3'd1;
                end
                if (r_idx == 2'd3) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt         = ST_DRIVE;
                    w_idx_nxt           = r_idx + 2'd1;
                    w_hcnt_nxt          = '0;
                    {w_a_nxt, w_b_nxt}  = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign done      = (r_state == ST_DONE);
    assign pass      = done && (r_err_vec == 4'd0);
    assign err_vec   = r_err_vec;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
